bcd_key_entry: RTL

Debounced keypad digit-entry stage that sits directly downstream of the 10-line-to-BCD priority encoder. It consumes the encoder's active-low BCD code and an active-low any-key line, both asynchronous to the clock. It synchronizes and debounces each press, then shifts accepted digits into an NDIG-digit packed-BCD buffer. The completed number is handed to the consumer over a valid/ready handshake.

---
 rtl/bcd_key_entry.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bcd_key_entry.sv
// Keypad digit-entry stage: synchronizes and debounces the active-low encoder
// outputs, then packs accepted digits into an NDIG-digit BCD number with valid/ready.
module bcd_key_entry #(
    parameter int DEB_CYCLES = 16,
    parameter int NDIG       = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_key_n,
    input  logic [0:3]        i_bcd_n,
    output logic              o_key_stb,
    output logic [3:0]        o_key_digit,
    output logic [4*NDIG-1:0] o_num,
    output logic              o_num_valid,
    input  logic              i_num_ready,
    output logic              o_ovf
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int DW = $clog2(NDIG + 1);
    localparam int NW = 4 * NDIG;

    // state          | meaning
    // S_IDLE         | no key seen
    // S_PRESS_WAIT   | key low, counting stable samples of one code
    // S_HELD         | press accepted, waiting for release
    // S_RELEASE_WAIT | key high, counting stable released samples
    typedef enum logic [1:0] {S_IDLE, S_PRESS_WAIT, S_HELD, S_RELEASE_WAIT} state_t;

    logic          r_key_s1, r_key_s2;
    logic [3:0]    r_bcd_s1, r_bcd_s2;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]    r_lat, w_lat_nxt;
    logic [3:0]    w_d;
    logic          w_accept, w_legal, w_hs, w_full;
    logic [NW-1:0] r_num, w_num_base;
    logic [DW-1:0] r_dcnt;
    logic          r_num_valid, r_ovf, r_key_stb;
    logic [3:0]    r_key_digit;

    // Code bits are re-ordered into true weight order at the first flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
            r_bcd_s1 <= 4'hF;
            r_bcd_s2 <= 4'hF;
        end else begin
            r_key_s1 <= i_key_n;
            r_key_s2 <= r_key_s1;
            r_bcd_s1 <= {i_bcd_n[3], i_bcd_n[2], i_bcd_n[1], i_bcd_n[0]};
            r_bcd_s2 <= r_bcd_s1;
        end
    end

    assign w_d = ~r_bcd_s2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lat   <= w_lat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lat_nxt   = r_lat;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_key_s2) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = CW'(1);
                    w_lat_nxt   = w_d;
                end
            end
            S_PRESS_WAIT: begin
                if (r_key_s2) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_d != r_lat) begin
                    w_lat_nxt = w_d;
                    w_cnt_nxt = CW'(1);
                end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = CW'(DEB_CYCLES);
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_HELD: begin
                if (r_key_s2) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = CW'(1);
                end
            end
            S_RELEASE_WAIT: begin
                if (!r_key_s2) begin
                    w_state_nxt = S_HELD;
                end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A handshake on the accept edge frees the buffer before the new digit lands.
    assign w_legal    = w_accept && (r_lat <= 4'd9);
    assign w_hs       = r_num_valid && i_num_ready;
    assign w_full     = r_num_valid && !i_num_ready;
    assign w_num_base = w_hs ? '0 : r_num;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_stb   <= 1'b0;
            r_key_digit <= '0;
            r_num       <= '0;
            r_num_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_dcnt      <= '0;
        end else begin
            r_key_stb <= w_legal;
            if (w_legal) r_key_digit <= r_lat;
            if (w_hs) begin
                r_num       <= '0;
                r_num_valid <= 1'b0;
                r_ovf       <= 1'b0;
            end
            if (w_legal) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_num <= (w_num_base << 4) | NW'(r_lat);
                    if (r_dcnt == DW'(NDIG - 1)) begin
                        r_dcnt      <= '0;
                        r_num_valid <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt + DW'(1);
                    end
                end
            end
        end
    end

    assign o_key_stb   = r_key_stb;
    assign o_key_digit = r_key_digit;
    assign o_num       = r_num;
    assign o_num_valid = r_num_valid;
    assign o_ovf       = r_ovf;
endmodule
